// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory target with wait states
// Word RAM with byte lanes; response data/error are registered on entry to RESP.
module dmem_responder #(
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_wstrb;
  logic [31:0]       mem [DEPTH];

  logic              accept, enter_resp;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [31:0]       a_wdata;
  logic [3:0]        a_wstrb;
  logic [ADDR_W-3:0] a_widx;
  logic              a_err;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          accept   = 1'b1;
          state_nx = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT:    if (cnt <= 4'd1) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    enter_resp = (state_nx == RESP) && (state != RESP);
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  // With zero latency the access happens on the accept edge, so use the live request.
  always_comb begin
    a_addr  = (state == IDLE) ? req_addr  : lat_addr;
    a_we    = (state == IDLE) ? req_we    : lat_we;
    a_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    a_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;
    a_widx  = a_addr[ADDR_W-1:2];
    a_err   = (a_addr[1:0] != 2'b00) || (a_widx >= (ADDR_W-2)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr  <= req_addr;
        lat_we    <= req_we;
        lat_wdata <= req_wdata;
        lat_wstrb <= req_wstrb;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= a_err;
        rsp_rdata <= (a_we || a_err) ? '0 : mem[a_widx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i]) mem[a_widx[AW-1:0]][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder with a transaction-level model
// u_dut uses LATENCY=2 and is tracked every cycle by the model; u_dut0 uses LATENCY=0.
module tb_dmem_responder;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req2_valid = 1'b0, req2_ready, req2_we = 1'b0;
  logic [31:0] req2_addr = '0, req2_wdata = '0;
  logic [3:0]  req2_wstrb = '0;
  logic        rsp2_valid, rsp2_ready = 1'b1, rsp2_err, busy2;
  logic [31:0] rsp2_rdata;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(L), .INIT_FILE("")) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req2_valid), .req_ready(req2_ready),
    .req_addr(req2_addr), .req_we(req2_we), .req_wdata(req2_wdata), .req_wstrb(req2_wstrb),
    .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready), .rsp_rdata(rsp2_rdata),
    .rsp_err(rsp2_err), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Transaction model: one request in flight, response visible L edges after accept.
  logic [31:0] mm [1024];
  bit          m_out = 0, chk_en = 0;
  int          m_age = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_we, m_err;

  task m_resolve;
    logic [29:0] w;
    w       = m_addr[31:2];
    m_err   = (m_addr[1:0] != 2'b00) || (w >= 30'd1024);
    m_rdata = '0;
    if (!m_err) begin
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_wstrb[i]) mm[w[9:0]][8*i +: 8] = m_wdata[8*i +: 8];
      end else begin
        m_rdata = mm[w[9:0]];
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_out = 0;
    end else if (m_out) begin
      if (m_age >= L && rsp_ready) m_out = 0;
      else begin
        m_age++;
        if (m_age == L) m_resolve();
      end
    end else if (req_valid) begin
      m_out = 1; m_age = 0;
      m_addr = req_addr; m_we = req_we; m_wdata = req_wdata; m_wstrb = req_wstrb;
      if (L == 0) m_resolve();
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("req_ready", req_ready, !reset && !m_out);
      chk1("rsp_valid", rsp_valid, m_out && m_age >= L);
      chk1("busy", busy, m_out);
      if (m_out && m_age >= L) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk1("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic wait_accept(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    chk1({name, "_accept_timeout"}, got, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int lat);
    bit got = 0;
    req_valid = 1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = st; rsp_ready = 1;
    wait_accept("xact");
    req_valid = 0; req_addr = $urandom; req_we = 1'($urandom);
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    lat = 0; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = i; rd = rsp_rdata; er = rsp_err; end
    end
    chk1("xact_rsp_timeout", got, 1'b1);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, nacc, nrsp, last_acc;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_req_ready", req_ready, 1'b0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk1("reset_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk1("ready_after_release", req_ready, 1'b1);
    @(posedge clk); #1;

    xact(32'h10, 1, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("t1_write_rdata", rd, 32'h0);
    chk("t1_write_lat", 32'(lat), 32'd3);
    xact(32'h10, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t1_read_rdata", rd, 32'hDEADBEEF);
    chk1("t1_read_err", er, 1'b0);
    chk("t1_read_lat", 32'(lat), 32'd3);

    xact(32'h10, 1, 32'h000000AA, 4'b0001, rd, er, lat);
    xact(32'h10, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t2_lane0", rd, 32'hDEADBEAA);
    xact(32'h10, 1, 32'h55555555, 4'b0000, rd, er, lat);
    chk1("t2_strb0_err", er, 1'b0);
    xact(32'h10, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t2_strb0_read", rd, 32'hDEADBEAA);

    xact(32'h12, 1, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk1("t3_misaligned_err", er, 1'b1);
    chk("t3_misaligned_rdata", rd, 32'h0);
    xact(32'h10, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t3_unchanged", rd, 32'hDEADBEAA);
    xact(32'h1000, 0, 32'h0, 4'h0, rd, er, lat);
    chk1("t3_oor_err", er, 1'b1);
    chk("t3_oor_rdata", rd, 32'h0);

    req_valid = 1; req_addr = 32'h10; req_we = 0; rsp_ready = 0;
    wait_accept("t4");
    req_valid = 0;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) got = 1;
      end
      chk1("t4_rsp_timeout", got, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk1("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_rdata", rsp_rdata, 32'hDEADBEAA);
      chk1("t4_hold_err", rsp_err, 1'b0);
      chk1("t4_hold_ready", req_ready, 1'b0);
      chk1("t4_hold_busy", busy, 1'b1);
      @(posedge clk); #1;
      req_valid = (k == 1); req_we = 1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    xact(32'h10, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t4_pulse_ignored", rd, 32'hDEADBEAA);

    xact(32'h20, 1, 32'h11112222, 4'hF, rd, er, lat);
    req_valid = 1; req_addr = 32'h20; req_we = 1; req_wdata = 32'h12345678; req_wstrb = 4'hF;
    wait_accept("t5");
    req_valid = 0; reset = 1;
    @(negedge clk);
    chk1("t5_wait_busy", busy, 1'b1);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk1("t5_after_rst_valid", rsp_valid, 1'b0);
    chk1("t5_after_rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    xact(32'h20, 0, 32'h0, 4'h0, rd, er, lat);
    chk("t5_not_committed", rd, 32'h11112222);

    req2_valid = 1; req2_we = 1; req2_addr = 32'h4; req2_wdata = 32'hCAFEF00D;
    req2_wstrb = 4'hF; rsp2_ready = 1;
    nacc = 0; nrsp = 0; last_acc = -10;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp2_valid) begin
        chk("t6_rsp_lat", 32'(k - last_acc), 32'd1);
        chk("t6_rdata", rsp2_rdata, (nrsp == 0) ? 32'h0 : 32'hCAFEF00D);
        chk1("t6_err", rsp2_err, 1'b0);
        nrsp++;
      end
      if (req2_ready) begin
        if (nacc > 0) chk("t6_spacing", 32'(k - last_acc), 32'd2);
        last_acc = k;
        nacc++;
      end
      @(posedge clk); #1;
      if (nacc > 0) req2_we = 0;
    end
    req2_valid = 0;
    chk("t6_accepts", 32'(nacc), 32'd6);
    chk("t6_responses", 32'(nrsp), 32'd6);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
